// File: rtl/pc_sequencer.sv
// Registered MIPS fetch-PC sequencer: next-PC selection, fetch stalls, JR alignment trap, halt-on-zero.
// Define PC_DELAY_SLOT_EN to enable architectural branch delay slots (SLOT state, link_pc = pc + 8).
module pc_sequencer #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic [1:0]        pc_sel,
  input  logic              is_true,
  input  logic [15:0]       imm,
  input  logic [25:0]       j_addr,
  input  logic [ADDR_W-1:0] reg_data_a,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_pc,
  output logic              in_delay_slot,
  output logic              addr_err,
  output logic              active
);

  typedef enum logic [1:0] {RUN, SLOT, HALT} state_e;
  typedef enum logic [1:0] {
    SEL_INC    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_JR     = 2'b11
  } sel_e;

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VECTOR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              addr_err_q, addr_err_d;
`ifdef PC_DELAY_SLOT_EN
  logic [ADDR_W-1:0] pending_q, pending_d;
`endif

  logic              advance;
  logic              redirect;
  logic              jr_misaligned;
  logic [ADDR_W-1:0] slot_pc;
  logic [ADDR_W-1:0] target;

  assign advance = instr_valid && !stall && (state_q != HALT);
  assign slot_pc = pc_q + ADDR_W'(4);

  // Target decode; all targets are relative to the delay-slot address pc + 4.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    redirect      = 1'b0;
    jr_misaligned = 1'b0;
    target        = '0;
    case (sel_e'(pc_sel))
      SEL_INC: ;
      SEL_BRANCH: begin
        redirect = is_true;
        target   = slot_pc + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
      end
      SEL_JUMP: begin
        redirect = 1'b1;
        target   = {slot_pc[ADDR_W-1:28], j_addr, 2'b00};
      end
      SEL_JR: begin
        jr_misaligned = (reg_data_a[1:0] != 2'b00);
        redirect      = !jr_misaligned;
        target        = reg_data_a;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_err_d = 1'b0;
`ifdef PC_DELAY_SLOT_EN
    pending_d  = pending_q;
`endif
    if (advance) begin
      case (state_q)
        RUN: begin
          if (jr_misaligned) begin
            pc_d       = EXC_PC;
            addr_err_d = 1'b1;
          end else if (redirect) begin
`ifdef PC_DELAY_SLOT_EN
            pc_d      = slot_pc;
            pending_d = target;
            state_d   = SLOT;
`else
            pc_d = target;
            if (target == '0) state_d = HALT;
`endif
          end else begin
            pc_d = slot_pc;
          end
        end
`ifdef PC_DELAY_SLOT_EN
        // The slot instruction's own pc_sel is ignored; the saved target wins.
        SLOT: begin
          pc_d      = pending_q;
          pending_d = '0;
          state_d   = (pending_q == '0) ? HALT : RUN;
        end
`endif
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RST_PC;
      addr_err_q <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
      pending_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_err_q <= addr_err_d;
`ifdef PC_DELAY_SLOT_EN
      pending_q  <= pending_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign addr_err = addr_err_q;
  assign active   = (state_q != HALT);
`ifdef PC_DELAY_SLOT_EN
  assign in_delay_slot = (state_q == SLOT);
  assign link_pc       = pc_q + ADDR_W'(8);
`else
  assign in_delay_slot = 1'b0;
  assign link_pc       = slot_pc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes hand-computed expectations, a monitor pops and compares.
// Expectations follow whichever PC_DELAY_SLOT_EN build is compiled.
module tb_pc_sequencer;

  localparam logic [1:0]  INC = 2'b00, BR = 2'b01, JMP = 2'b10, JR = 2'b11;
  localparam logic [31:0] RV  = 32'hBFC0_0000;
`ifdef PC_DELAY_SLOT_EN
  localparam logic [31:0] LINK_OFF = 32'd8;
`else
  localparam logic [31:0] LINK_OFF = 32'd4;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        ds;
    logic        ae;
    logic        act;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        instr_valid;
  logic [1:0]  pc_sel;
  logic        is_true;
  logic [15:0] imm;
  logic [25:0] j_addr;
  logic [31:0] reg_data_a;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        in_delay_slot;
  logic        addr_err;
  logic        active;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .instr_valid  (instr_valid),
    .pc_sel       (pc_sel),
    .is_true      (is_true),
    .imm          (imm),
    .j_addr       (j_addr),
    .reg_data_a   (reg_data_a),
    .pc           (pc),
    .link_pc      (link_pc),
    .in_delay_slot(in_delay_slot),
    .addr_err     (addr_err),
    .active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Apply one cycle of inputs and record what the outputs must show during that cycle.
  task automatic drv(input logic v, input logic st, input logic [1:0] sel, input logic t,
                     input logic [15:0] im, input logic [25:0] ja, input logic [31:0] ra,
                     input logic [31:0] epc, input logic eds, input logic eae, input logic eact);
    exp_t e;
    @(posedge clk);
    #1;
    instr_valid = v;
    stall       = st;
    pc_sel      = sel;
    is_true     = t;
    imm         = im;
    j_addr      = ja;
    reg_data_a  = ra;
    e.pc  = epc;
    e.ds  = eds;
    e.ae  = eae;
    e.act = eact;
    sb.push_back(e);
  endtask

  task automatic inc(input logic [31:0] epc, input logic eds, input logic eae);
    drv(1'b1, 1'b0, INC, 1'b0, 16'h0, 26'h0, 32'h0, epc, eds, eae, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    inc(RV, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] link_exp;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e        = sb.pop_front();
        link_exp = e.pc + LINK_OFF;
        check("pc", pc, e.pc);
        check("link_pc", link_pc, link_exp);
        check("in_delay_slot", {31'b0, in_delay_slot}, {31'b0, e.ds});
        check("addr_err", {31'b0, addr_err}, {31'b0, e.ae});
        check("active", {31'b0, active}, {31'b0, e.act});
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; instr_valid = 1'b0; stall = 1'b0; pc_sel = INC;
    is_true = 1'b0; imm = '0; j_addr = '0; reg_data_a = '0;

    inc(RV, 1'b0, 1'b0);
    rst_n = 1'b1;
    inc(32'hBFC0_0004, 1'b0, 1'b0);
    inc(32'hBFC0_0008, 1'b0, 1'b0);
    drv(1'b1, 1'b1, INC, 1'b0, 16'h0, 26'h0, 32'h0, 32'hBFC0_000C, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, INC, 1'b0, 16'h0, 26'h0, 32'h0, 32'hBFC0_000C, 1'b0, 1'b0, 1'b1);
    inc(32'hBFC0_000C, 1'b0, 1'b0);
    drv(1'b1, 1'b0, BR, 1'b1, 16'hFFFE, 26'h0, 32'h0, 32'hBFC0_0010, 1'b0, 1'b0, 1'b1);
`ifdef PC_DELAY_SLOT_EN
    inc(32'hBFC0_0014, 1'b1, 1'b0);
`endif
    drv(1'b1, 1'b0, BR, 1'b0, 16'h0010, 26'h0, 32'h0, 32'hBFC0_000C, 1'b0, 1'b0, 1'b1);
    inc(32'hBFC0_0010, 1'b0, 1'b0);
    inc(32'hBFC0_0014, 1'b0, 1'b0);
    inc(32'hBFC0_0018, 1'b0, 1'b0);
    inc(32'hBFC0_001C, 1'b0, 1'b0);
    drv(1'b1, 1'b0, JMP, 1'b0, 16'h0, 26'h0000040, 32'h0, 32'hBFC0_0020, 1'b0, 1'b0, 1'b1);
`ifdef PC_DELAY_SLOT_EN
    for (int i = 0; i < 3; i++)
      drv(1'b1, 1'b1, JR, 1'b0, 16'h0, 26'h0, 32'h0, 32'hBFC0_0024, 1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b0, JR, 1'b0, 16'h0, 26'h0, 32'h0, 32'hBFC0_0024, 1'b1, 1'b0, 1'b1);
`else
    for (int i = 0; i < 3; i++)
      drv(1'b1, 1'b1, JR, 1'b0, 16'h0, 26'h0, 32'h0, 32'hB000_0100, 1'b0, 1'b0, 1'b1);
`endif
    inc(32'hB000_0100, 1'b0, 1'b0);
    drv(1'b1, 1'b0, JR, 1'b0, 16'h0, 26'h0, 32'h0040_0002, 32'hB000_0104, 1'b0, 1'b0, 1'b1);
    inc(32'hBFC0_0380, 1'b0, 1'b1);
    inc(32'hBFC0_0384, 1'b0, 1'b0);
    drv(1'b1, 1'b0, JR, 1'b0, 16'h0, 26'h0, 32'h0, 32'hBFC0_0388, 1'b0, 1'b0, 1'b1);
`ifdef PC_DELAY_SLOT_EN
    inc(32'hBFC0_038C, 1'b1, 1'b0);
`endif
    drv(1'b1, 1'b0, JMP, 1'b0, 16'h0, 26'h0000040, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b0, BR, 1'b1, 16'h0004, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b1, JR, 1'b0, 16'h0, 26'h0, 32'h0040_0002, 32'h0, 1'b0, 1'b0, 1'b0);

    pulse_reset();
    inc(32'hBFC0_0004, 1'b0, 1'b0);
    drv(1'b1, 1'b0, JMP, 1'b0, 16'h0, 26'h0, 32'h0, 32'hBFC0_0008, 1'b0, 1'b0, 1'b1);
`ifdef PC_DELAY_SLOT_EN
    inc(32'hBFC0_000C, 1'b1, 1'b0);
`else
    inc(32'hB000_0000, 1'b0, 1'b0);
`endif
    pulse_reset();
    inc(32'hBFC0_0004, 1'b0, 1'b0);
    drv(1'b1, 1'b0, JR, 1'b0, 16'h0, 26'h0, 32'h0040_0010, 32'hBFC0_0008, 1'b0, 1'b0, 1'b1);
`ifdef PC_DELAY_SLOT_EN
    inc(32'hBFC0_000C, 1'b1, 1'b0);
`endif
    inc(32'h0040_0010, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
